// File: rtl/gbuff_sram_bank_if.sv
// ---------------------------------------------------------------------------
// gbuff_sram_bank_if
// Request/response bundle between the externally arbitrated DMA/PE-feeder
// master and the global-buffer SRAM bank.
//   master drives : clear, req, wen, addr, wmask, wdata
//   slave drives  : ready, busy, rdata, rvalid, err
// ---------------------------------------------------------------------------
interface gbuff_sram_bank_if #(
    parameter int WORD_W = 128,
    parameter int ADDR_W = 10
);
    logic                  clear;
    logic                  req;
    logic                  wen;
    logic [ADDR_W-1:0]     addr;
    logic [WORD_W/8-1:0]   wmask;
    logic [WORD_W-1:0]     wdata;
    logic                  ready;
    logic                  busy;
    logic [WORD_W-1:0]     rdata;
    logic                  rvalid;
    logic                  err;

    modport master (
        output clear, req, wen, addr, wmask, wdata,
        input  ready, busy, rdata, rvalid, err
    );

    modport slave (
        input  clear, req, wen, addr, wmask, wdata,
        output ready, busy, rdata, rvalid, err
    );
endinterface

// File: rtl/gbuff_sram_bank.sv
// ---------------------------------------------------------------------------
// gbuff_sram_bank
// Parametrised global-buffer SRAM bank: byte-masked writes, pipelined reads
// with 1 (OUT_REG=0) or 2 (OUT_REG=1) cycle latency, and a multi-cycle
// zero-fill sequencer with a ready/busy handshake.
// Ports:
//   clk    - clock, rising edge
//   reset  - synchronous, active-high; restarts the clear sequence
//   bus    - gbuff_sram_bank_if.slave (clear/req/wen/addr/wmask/wdata in,
//            ready/busy/rdata/rvalid/err out)
// ---------------------------------------------------------------------------
module gbuff_sram_bank #(
    parameter int WORD_W  = 128,
    parameter int DEPTH   = 1024,
    parameter int ADDR_W  = 10,
    parameter int OUT_REG = 0
) (
    input  logic              clk,
    input  logic              reset,
    gbuff_sram_bank_if.slave  bus
);
    localparam int NB = WORD_W / 8;

    typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

    state_t              state_reg;
    logic [ADDR_W-1:0]   clr_addr_reg;

    logic                in_range;
    logic                accept;
    logic                rd_fire;
    logic                wr_fire;

    logic [NB-1:0]       mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [WORD_W-1:0]   mem_wdata;
    logic [WORD_W-1:0]   ram_q;

    logic                s1_valid_reg;
    logic                s1_oor_reg;
    logic                wr_err_reg;
    logic [WORD_W-1:0]   s1_data;

    logic                out_valid;
    logic                out_rerr;
    logic [WORD_W-1:0]   out_data;

    // Extra MSB so DEPTH == 2**ADDR_W does not truncate to zero.
    assign in_range = {1'b0, bus.addr} < (ADDR_W+1)'(DEPTH);
    assign accept   = bus.req & (state_reg == ST_IDLE) & ~reset;
    assign rd_fire  = accept & ~bus.wen;
    assign wr_fire  = accept &  bus.wen & in_range;

    // Single write port shared by the clear sequencer and host writes; they
    // never collide because requests are only accepted in IDLE.
    always_comb begin
        mem_we    = '0;
        mem_waddr = bus.addr;
        mem_wdata = bus.wdata;
        if (state_reg == ST_CLEAR && !reset) begin
            mem_we    = '1;
            mem_waddr = clr_addr_reg;
            mem_wdata = '0;
        end else if (wr_fire) begin
            mem_we    = bus.wmask;
        end
    end

    // One byte-wide RAM per lane keeps the byte enables trivially mappable.
    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];
            logic [7:0] q_reg;

            always_ff @(posedge clk) begin
                if (mem_we[gi])
                    lane_mem[mem_waddr] <= mem_wdata[gi*8 +: 8];
                if (rd_fire && in_range)
                    q_reg <= lane_mem[bus.addr];
            end

            assign ram_q[gi*8 +: 8] = q_reg;
        end
    endgenerate

    // Clear sequencer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_CLEAR;
            clr_addr_reg <= '0;
        end else begin
            case (state_reg)
                ST_CLEAR: begin
                    clr_addr_reg <= clr_addr_reg + 1'b1;
                    if (clr_addr_reg == ADDR_W'(DEPTH - 1))
                        state_reg <= ST_IDLE;
                end
                default: begin
                    // A read accepted together with clear still completes:
                    // its data was captured this cycle, before the fill.
                    if (bus.clear) begin
                        state_reg    <= ST_CLEAR;
                        clr_addr_reg <= '0;
                    end
                end
            endcase
        end
    end

    // First read stage and write-error strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_reg <= 1'b0;
            s1_oor_reg   <= 1'b0;
            wr_err_reg   <= 1'b0;
        end else begin
            s1_valid_reg <= rd_fire;
            s1_oor_reg   <= rd_fire & ~in_range;
            wr_err_reg   <= accept & bus.wen & ~in_range;
        end
    end

    assign s1_data = s1_oor_reg ? '0 : ram_q;

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic              rvalid_reg;
            logic              rerr_reg;
            logic [WORD_W-1:0] rdata_reg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    rvalid_reg <= 1'b0;
                    rerr_reg   <= 1'b0;
                    rdata_reg  <= '0;
                end else begin
                    rvalid_reg <= s1_valid_reg;
                    rerr_reg   <= s1_valid_reg & s1_oor_reg;
                    if (s1_valid_reg)
                        rdata_reg <= s1_data;
                end
            end

            assign out_valid = rvalid_reg;
            assign out_rerr  = rerr_reg;
            assign out_data  = rdata_reg;
        end else begin : g_noreg
            // RAM output is only valid in the strobe cycle; the hold register
            // keeps rdata stable between responses.
            logic [WORD_W-1:0] hold_reg;

            always_ff @(posedge clk) begin
                if (reset)
                    hold_reg <= '0;
                else if (s1_valid_reg)
                    hold_reg <= s1_data;
            end

            assign out_valid = s1_valid_reg;
            assign out_rerr  = s1_valid_reg & s1_oor_reg;
            assign out_data  = s1_valid_reg ? s1_data : hold_reg;
        end
    endgenerate

    // Outputs are forced quiet in any cycle where reset is held, so a read
    // whose response would land in a reset cycle never shows up.
    assign bus.rvalid = out_valid & ~reset;
    assign bus.rdata  = reset ? '0 : out_data;
    assign bus.err    = (out_rerr | wr_err_reg) & ~reset;
    assign bus.ready  = (state_reg == ST_IDLE) & ~reset;
    assign bus.busy   = ~bus.ready;
endmodule

// File: tb/tb_gbuff_sram_bank.sv
module tb_gbuff_sram_bank;
    localparam int W  = 128;
    localparam int D  = 1000;
    localparam int AW = 10;
    localparam int NB = W / 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic           t_clear, t_req, t_wen;
    logic [AW-1:0]  t_addr;
    logic [NB-1:0]  t_wmask;
    logic [W-1:0]   t_wdata;

    gbuff_sram_bank_if #(.WORD_W(W), .ADDR_W(AW)) if0 ();
    gbuff_sram_bank_if #(.WORD_W(W), .ADDR_W(AW)) if1 ();

    assign if0.clear = t_clear;  assign if1.clear = t_clear;
    assign if0.req   = t_req;    assign if1.req   = t_req;
    assign if0.wen   = t_wen;    assign if1.wen   = t_wen;
    assign if0.addr  = t_addr;   assign if1.addr  = t_addr;
    assign if0.wmask = t_wmask;  assign if1.wmask = t_wmask;
    assign if0.wdata = t_wdata;  assign if1.wdata = t_wdata;

    gbuff_sram_bank #(.WORD_W(W), .DEPTH(D), .ADDR_W(AW), .OUT_REG(0)) dut0 (
        .clk(clk), .reset(reset), .bus(if0));
    gbuff_sram_bank #(.WORD_W(W), .DEPTH(D), .ADDR_W(AW), .OUT_REG(1)) dut1 (
        .clk(clk), .reset(reset), .bus(if1));

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: word array, countdown of remaining clear cycles,
    // and a per-latency list of pending read responses.
    logic [W-1:0] mm [D];
    bit           m_ready;
    int           clr_left;
    bit           pv [2];
    bit           pe [2];
    logic [W-1:0] pd [2];
    bit           werr;
    logic [W-1:0] hold [2];
    bit           started = 0;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        logic [W-1:0] g_d [2];
        logic         g_v [2];
        logic         g_e [2];
        logic         g_r [2];
        logic         g_b [2];
        g_d[0] = if0.rdata;  g_d[1] = if1.rdata;
        g_v[0] = if0.rvalid; g_v[1] = if1.rvalid;
        g_e[0] = if0.err;    g_e[1] = if1.err;
        g_r[0] = if0.ready;  g_r[1] = if1.ready;
        g_b[0] = if0.busy;   g_b[1] = if1.busy;
        for (int k = 0; k < 2; k++) begin
            bit           ev, ee, er;
            logic [W-1:0] ed;
            // dut k delivers a read k+1 edges after acceptance
            ev = reset ? 1'b0 : pv[k];
            ed = reset ? '0 : (pv[k] ? pd[k] : hold[k]);
            ee = reset ? 1'b0 : (pe[k] | werr);
            er = m_ready && !reset;
            chk($sformatf("rvalid_lat%0d", k + 1), W'(g_v[k]), W'(ev));
            chk($sformatf("rdata_lat%0d", k + 1), g_d[k], ed);
            chk($sformatf("err_lat%0d", k + 1), W'(g_e[k]), W'(ee));
            chk($sformatf("ready_lat%0d", k + 1), W'(g_r[k]), W'(er));
            chk($sformatf("busy_lat%0d", k + 1), W'(g_b[k]), W'(!er));
        end
    endtask

    // Check the current cycle, advance the model over one clock edge.
    task automatic step();
        bit           acc, inr, nv, ne, nwe;
        logic [W-1:0] nd;
        #1;
        if (started) check_outputs();
        acc = t_req && m_ready && !reset;
        inr = int'(t_addr) < D;
        nv  = acc && !t_wen;
        ne  = acc && !t_wen && !inr;
        nwe = acc && t_wen && !inr;
        nd  = '0;
        if (inr) nd = mm[t_addr];
        @(posedge clk);
        if (reset) begin
            m_ready  = 0;
            clr_left = D;
            pv[0] = 0; pv[1] = 0; pe[0] = 0; pe[1] = 0;
            werr = 0; hold[0] = '0; hold[1] = '0;
        end else begin
            if (!m_ready) begin
                mm[D - clr_left] = '0;
                clr_left--;
                if (clr_left == 0) m_ready = 1;
            end else begin
                if (acc && t_wen && inr)
                    for (int b = 0; b < NB; b++)
                        if (t_wmask[b]) mm[t_addr][b*8 +: 8] = t_wdata[b*8 +: 8];
                if (t_clear) begin
                    m_ready  = 0;
                    clr_left = D;
                end
            end
            pv[1] = pv[0]; pe[1] = pe[0]; pd[1] = pd[0];
            pv[0] = nv;    pe[0] = ne;    pd[0] = nd;
            werr  = nwe;
            for (int k = 0; k < 2; k++) if (pv[k]) hold[k] = pd[k];
        end
        started = 1;
        #1;
    endtask

    task automatic set_idle();
        t_req = 0; t_clear = 0; t_wen = 0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [NB-1:0] m, input logic [W-1:0] d);
        t_req = 1; t_wen = 1; t_addr = a; t_wmask = m; t_wdata = d;
        step();
        set_idle();
    endtask

    task automatic do_read(input logic [AW-1:0] a);
        t_req = 1; t_wen = 0; t_addr = a;
        step();
        set_idle();
    endtask

    task automatic count_busy(input string tag);
        int n = 0;
        while (if0.busy && n < 1100) begin
            step();
            n++;
        end
        chk(tag, W'(n), W'(D));
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!if0.ready && n < 1100) begin
            step();
            n++;
        end
        chk("ready_timeout", W'(if0.ready), W'(1));
    endtask

    function automatic logic [W-1:0] rand_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    localparam logic [W-1:0] MERGED = {{12{8'hFF}}, 32'h11223344};

    initial begin
        for (int i = 0; i < D; i++) mm[i] = '0;
        pv[0] = 0; pv[1] = 0; pe[0] = 0; pe[1] = 0;
        pd[0] = '0; pd[1] = '0; hold[0] = '0; hold[1] = '0;
        werr = 0; m_ready = 0; clr_left = D;
        t_addr = '0; t_wmask = '0; t_wdata = '0;
        set_idle();

        // Reset init and clear length
        reset = 1;
        repeat (3) step();
        reset = 0;
        count_busy("init_clear_len");
        chk("ready_after_clear", W'(if0.ready), W'(1));

        // Read of a freshly cleared word
        do_read(10'd5);
        chk("rd5_rvalid", W'(if0.rvalid), W'(1));
        chk("rd5_rdata", if0.rdata, '0);
        step();

        // Masked write merge
        do_write(10'd3, '1, '1);
        do_write(10'd3, 16'h000F, 128'h11223344);
        do_read(10'd3);
        chk("mask_rdata", if0.rdata, MERGED);
        step();

        // Back-to-back reads
        for (int a = 0; a < 3; a++) do_write(AW'(a), '1, rand_word());
        t_req = 1; t_wen = 0;
        for (int a = 0; a < 3; a++) begin
            t_addr = AW'(a);
            step();
        end
        set_idle();
        repeat (3) step();

        // Clear together with a read; requests while busy are dropped
        t_req = 1; t_wen = 0; t_addr = 10'd3; t_clear = 1;
        step();
        set_idle();
        chk("clr_rd_rdata", if0.rdata, MERGED);
        chk("clr_busy", W'(if0.busy), W'(1));
        do_write(10'd7, '1, rand_word());
        do_read(10'd3);
        t_clear = 1; step(); t_clear = 0;
        wait_ready();
        do_read(10'd3);
        chk("post_clear_rd3", if0.rdata, '0);
        do_read(10'd7);
        chk("post_clear_rd7", if0.rdata, '0);
        step();

        // Out of range
        do_write(10'd4, '1, rand_word());
        do_write(10'd1010, '1, rand_word());
        chk("oor_wr_err", W'(if0.err), W'(1));
        step();
        do_read(10'd1010);
        chk("oor_rd_rvalid", W'(if0.rvalid), W'(1));
        chk("oor_rd_err", W'(if0.err), W'(1));
        chk("oor_rd_rdata", if0.rdata, '0);
        step();
        step();

        // Randomised traffic
        for (int i = 0; i < 900; i++) begin
            t_req   = ($urandom_range(0, 9) < 7);
            t_wen   = $urandom_range(0, 1);
            t_addr  = ($urandom_range(0, 9) == 0) ? AW'(D + $urandom_range(0, 23))
                                                  : AW'($urandom_range(0, 15));
            t_wmask = NB'($urandom);
            t_wdata = rand_word();
            t_clear = ($urandom_range(0, 399) == 0);
            step();
        end
        set_idle();
        wait_ready();

        // Reset while a read is in flight
        do_write(10'd9, '1, rand_word());
        t_req = 1; t_wen = 0; t_addr = 10'd9;
        step();
        set_idle();
        reset = 1;
        #1;
        chk("rst_mid_rvalid", W'(if0.rvalid), W'(0));
        chk("rst_mid_rdata", if0.rdata, '0);
        step();
        reset = 0;
        count_busy("reset_clear_len");
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/gbuff_sram_bank.md
Name: gbuff_sram_bank

Overview:
- Parametrised global-buffer SRAM for the TinyML accelerator. Successor to the single fixed-width buffer.
- Adds configurable word width, depth and read latency, plus byte-masked writes and a read-valid strobe.
- Adds a multi-cycle clear sequencer that replaces the single-cycle whole-array reset, with a ready/busy handshake.
- Sits between the DMA/loader and the PE-array feeders. Both masters arbitrate externally and drive one request port.

Parameters:
- WORD_W, 128, data word width in bits; must be a multiple of 8.
- DEPTH, 1024, number of words; need not be a power of two.
- ADDR_W, 10, address width; must satisfy 2**ADDR_W >= DEPTH.
- OUT_REG, 0, 0: read latency 1 cycle; 1: extra output register, read latency 2 cycles.

Ports:
- clk  input  1  clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- clear  input  1  request zero-fill of the whole array
- req  input  1  access request, sampled when ready=1
- wen  input  1  1=write, 0=read (qualified by req)
- addr  input  ADDR_W  word address
- wmask  input  WORD_W/8  byte write enables; bit i covers data[8i+7:8i]
- wdata  input  WORD_W  write data
- ready  output  1  block accepts req this cycle
- busy  output  1  clear sequence in progress (equals ~ready)
- rdata  output  WORD_W  read data
- rvalid  output  1  one-cycle strobe: rdata valid
- err  output  1  one-cycle strobe alongside rvalid, or the cycle after an out-of-range write

Behaviour:
- Reset:
  - Clock is clk. Reset is `reset`: synchronous, active-high.
  - While reset=1: rdata=0, rvalid=0, err=0, in-flight reads discarded, FSM forced to CLEAR with clr_addr=0.
  - Consequently busy=1 and ready=0 during reset and after it is released.
- FSM states: CLEAR and IDLE.
  - CLEAR: each cycle writes all-zero to mem[clr_addr] and increments clr_addr.
  - CLEAR -> IDLE: on the cycle that writes clr_addr=DEPTH-1. The whole clear takes exactly DEPTH cycles after reset deasserts.
  - IDLE -> CLEAR: on clear=1, with clr_addr reset to 0.
  - clear=1 while in CLEAR is ignored; the counter is not restarted.
- Handshake:
  - ready=1 only in IDLE.
  - A request is accepted iff req & ready. req while busy is dropped: no memory effect, no rvalid.
  - clear=1 and an accepted req in the same IDLE cycle: the req is serviced, including its read response, and CLEAR starts the next cycle.
- Write (accepted, wen=1, addr<DEPTH):
  - mem[addr] bytes with wmask=1 take wdata; other bytes are unchanged. Visible to a read accepted the next cycle.
  - wmask=0 is a legal no-op.
- Read (accepted, wen=0):
  - rvalid pulses exactly 1+OUT_REG cycles after acceptance, with rdata=mem[addr] as of the acceptance cycle.
  - Back-to-back reads give one result per cycle (fully pipelined).
  - rdata holds its last value when rvalid=0.
- Out of range (addr>=DEPTH):
  - Write: memory is unchanged; err pulses the next cycle.
  - Read: returns rdata=0 with rvalid=1 and err=1 at the normal latency.
- In-flight reads when a clear starts complete normally with pre-clear data.
- Read of the same address as the previous cycle's write returns the merged new word. No bypass is needed because the write commits first.

Test Plan:
- Reset init: assert reset for 3 cycles, release -> busy=1 for exactly DEPTH cycles, then ready=1. A read of addr 5 returns 0 with rvalid at +1 (OUT_REG=0).
- Masked write: write 0x...FF at addr 3 with wmask all ones, then write 0x11223344 with wmask=0x000F -> read addr 3 returns upper 12 bytes 0xFF and low bytes 0x11223344.
- Pipelined reads, OUT_REG=1: accept reads of addrs 0,1,2 on consecutive cycles -> rvalid high 3 consecutive cycles starting 2 cycles after the first, data in order.
- Clear handshake: in IDLE, pulse clear together with a read of addr 3 -> read returns old data, busy rises the next cycle for DEPTH cycles. A req issued while busy has no effect. Afterwards all reads return 0.
- Out of range, DEPTH=1000 / ADDR_W=10:
  - Write addr 1010 -> err pulses the next cycle, memory unchanged.
  - Read addr 1010 -> rdata=0, rvalid=1, err=1.
- Reset mid-read: accept a read, assert reset the next cycle -> no rvalid ever appears for it, rdata=0, and the clear sequence restarts from 0.
